// File: rtl/free_list_ckpt.sv
// -----------------------------------------------------------------------------
// free_list_ckpt
//
// Physical-register free list for the rename stage, with branch checkpoints.
// The list is a circular buffer of FL_DEPTH tags. Allocation pops from head
// and retire pushes released tags at tail. A checkpoint saves a copy of head
// that a mispredict can later restore.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous, active-low reset
//   disp_req         per-lane request for a destination tag
//   rt_en            per-lane retire; release the matching rt_Told tag
//   rt_Told          packed released tags, lane 0 in the LSBs
//   br_wr_en         per-lane branch dispatch; take a checkpoint
//   br_marker        packed checkpoint slot for each lane
//   br_mispredict    restore head from checkpoint br_mispre_marker
//   br_mispre_marker checkpoint slot to restore
//   fl_T             packed allocated tags; combinational from disp_req
//   fl_free_cnt      number of free entries, taken from the pointer registers
//   fl_avail         min(fl_free_cnt, WAYS)
//   fl_empty         fl_free_cnt == 0
// -----------------------------------------------------------------------------
module free_list_ckpt #(
   parameter int PREG_NUM  = 64,
   parameter int AREG_NUM  = 32,
   parameter int WAYS      = 2,
   parameter int BR_DEPTH  = 4,
   parameter int ZERO_PREG = 31,
   localparam int PW       = $clog2(PREG_NUM),
   localparam int BW       = $clog2(BR_DEPTH),
   localparam int FL_DEPTH = PREG_NUM - AREG_NUM,
   localparam int CW       = $clog2(FL_DEPTH) + 1,
   localparam int AW       = $clog2(WAYS + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WAYS-1:0]      disp_req,
   input  logic [WAYS-1:0]      rt_en,
   input  logic [WAYS*PW-1:0]   rt_Told,
   input  logic [WAYS-1:0]      br_wr_en,
   input  logic [WAYS*BW-1:0]   br_marker,
   input  logic                 br_mispredict,
   input  logic [BW-1:0]        br_mispre_marker,
   output logic [WAYS*PW-1:0]   fl_T,
   output logic [CW-1:0]        fl_free_cnt,
   output logic [AW-1:0]        fl_avail,
   output logic                 fl_empty
);

   localparam int FW = CW - 1;

   // Pointers carry one wrap bit above the buffer index, so a full list
   // (tail - head == FL_DEPTH) and an empty list (tail == head) differ.
   logic [CW-1:0] head;
   logic [CW-1:0] tail;
   logic [PW-1:0] fl_buf [FL_DEPTH];
   logic [CW-1:0] br_h   [BR_DEPTH];

   // Per-lane compacted positions and checkpoint values.
   logic [FW-1:0] alloc_idx [WAYS];
   logic [FW-1:0] rel_idx   [WAYS];
   logic [CW-1:0] ckpt_val  [WAYS];
   logic [CW-1:0] alloc_run;
   logic [CW-1:0] rel_run;

   // Lanes are compacted: a requesting lane takes the next entry after all
   // lower requesting lanes, and a releasing lane writes likewise behind tail.
   always_comb begin
      // NOTE: blocking assignments here make the running counts visible to the
      // next loop iteration inside this same evaluation; every output gets a
      // default first so no latch is inferred.
      alloc_run = '0;
      rel_run   = '0;
      fl_T      = '0;
      for (int i = 0; i < WAYS; i++) begin
         alloc_idx[i] = head[FW-1:0] + alloc_run[FW-1:0];
         rel_idx[i]   = tail[FW-1:0] + rel_run[FW-1:0];
         // The branch's own destination counts as already allocated.
         ckpt_val[i]  = head + alloc_run + CW'(disp_req[i]);
         fl_T[i*PW +: PW] = disp_req[i] ? fl_buf[alloc_idx[i]] : PW'(ZERO_PREG);
         alloc_run    = alloc_run + CW'(disp_req[i]);
         rel_run      = rel_run + CW'(rt_en[i]);
      end
   end

   // Buffer storage: releases land at the edge and are allocatable next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: this memory is reset on purpose, because after reset the list
         // must already hold tags AREG_NUM .. PREG_NUM-1; plain storage that
         // carries no reset meaning should be left without one.
         for (int k = 0; k < FL_DEPTH; k++) begin
            fl_buf[k] <= PW'(AREG_NUM + k);
         end
      end else begin
         for (int i = 0; i < WAYS; i++) begin
            if (rt_en[i]) begin
               fl_buf[rel_idx[i]] <= rt_Told[i*PW +: PW];
            end
         end
      end
   end

   // Pointers and checkpoints.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         tail <= CW'(FL_DEPTH);
         for (int j = 0; j < BR_DEPTH; j++) begin
            br_h[j] <= '0;
         end
      end else begin
         // Retire applies even in a mispredict cycle.
         tail <= tail + rel_run;
         if (br_mispredict) begin
            // Dispatch and checkpoint writes from this cycle are squashed.
            head <= br_h[br_mispre_marker];
         end else begin
            head <= head + alloc_run;
            for (int i = 0; i < WAYS; i++) begin
               // NOTE: when two lanes name the same slot, the later
               // non-blocking write (higher lane) is the one that sticks.
               if (br_wr_en[i]) begin
                  br_h[br_marker[i*BW +: BW]] <= ckpt_val[i];
               end
            end
         end
      end
   end

   // Status outputs derive only from the pointer registers; same-cycle
   // releases are not counted.
   always_comb begin
      fl_free_cnt = tail - head;
      fl_empty    = (fl_free_cnt == '0);
      fl_avail    = (fl_free_cnt >= CW'(WAYS)) ? AW'(WAYS) : AW'(fl_free_cnt);
   end

endmodule
